// File: rtl/mfa_seq_ctrl.sv
// mfa_seq_ctrl: phase sequencer for the multifractal box-counting pipeline.
// The controller owns the box-count RAM ports and grants them to one master per
// phase: the pixel writer (BC), the square-grid merger (MERGE), or the host
// (IDLE/DONE). It also holds sqg idle via BC_mode, times the merge, and keeps
// the busy/done/err status flags.
module mfa_seq_ctrl #(
  parameter int BOX_IDX      = 3,
  parameter int DATA_LEN     = 8,
  parameter int NPIX         = 1 << (2 * BOX_IDX),
  parameter int MERGE_CYCLES = 84
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    bc_wen,
  input  logic [2*BOX_IDX:0]      bc_addr,
  input  logic [DATA_LEN-1:0]     bc_wdata,
  input  logic                    sqg_wen,
  input  logic [2*BOX_IDX:0]      sqg_rd_addr,
  input  logic [2*BOX_IDX:0]      sqg_wr_addr,
  input  logic [DATA_LEN-1:0]     sqg_y,
  input  logic [2*BOX_IDX:0]      host_addr,
  output logic                    BC_mode,
  output logic                    ram_wen,
  output logic [2*BOX_IDX:0]      ram_wr_addr,
  output logic [DATA_LEN-1:0]     ram_wdata,
  output logic [2*BOX_IDX:0]      ram_rd_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int AW = 2 * BOX_IDX + 1;
  localparam int MW = $clog2(MERGE_CYCLES) + 1;
  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [MW-1:0] MRG_LAST = MW'(MERGE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BC    = 2'd1,
    S_MERGE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pix_cnt_q, pix_cnt_d;
  logic [MW-1:0] mrg_cnt_q, mrg_cnt_d;
  logic          bc_mode_q, bc_mode_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  // Next-state, phase counters and registered status flags.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    mrg_cnt_d = mrg_cnt_q;

    case (state_q)
      S_IDLE: if (start) state_d = S_BC;
      S_BC: begin
        if (bc_wen) begin
          if (pix_cnt_q == PIX_LAST) begin
            state_d   = S_MERGE;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      S_MERGE: begin
        if (mrg_cnt_q == MRG_LAST) begin
          state_d   = S_DONE;
          mrg_cnt_d = '0;
        end else begin
          mrg_cnt_d = mrg_cnt_q + 1'b1;
        end
      end
      S_DONE:  if (start) state_d = S_BC;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every phase decision, including a same-cycle start.
    if (abort) begin
      state_d   = S_IDLE;
      pix_cnt_d = '0;
      mrg_cnt_d = '0;
    end

    // Status flags are derived from the next state so they line up with it.
    bc_mode_d = (state_d != S_MERGE);
    busy_d    = (state_d == S_BC) || (state_d == S_MERGE);
    done_d    = (state_d == S_DONE);

    // Protocol violations latch until reset; abort does not clear them.
    err_d = err_q
          | (bc_wen && (state_q != S_BC))
          | (sqg_wen && bc_mode_q)
          | (start && busy_q);
  end

  // RAM port mux: the current phase owner drives the ports, abort kills writes.
  always_comb begin
    ram_wen     = 1'b0;
    ram_wr_addr = '0;
    ram_wdata   = '0;
    ram_rd_addr = host_addr;
    case (state_q)
      S_BC: begin
        ram_wen     = bc_wen;
        ram_wr_addr = bc_addr;
        ram_wdata   = bc_wdata;
        ram_rd_addr = bc_addr;
      end
      S_MERGE: begin
        ram_wen     = sqg_wen;
        ram_wr_addr = sqg_wr_addr;
        ram_wdata   = sqg_y;
        ram_rd_addr = sqg_rd_addr;
      end
      default: ;
    endcase
    if (abort) ram_wen = 1'b0;
  end

  // State and status registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
      mrg_cnt_q <= '0;
      bc_mode_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      mrg_cnt_q <= mrg_cnt_d;
      bc_mode_q <= bc_mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign BC_mode = bc_mode_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mfa_seq_ctrl.sv
// tb_mfa_seq_ctrl: directed bench for the box-counting sequencer. Every RAM
// write the DUT presents is matched against a queue of expected writes filled
// by the stimulus; status and read-port values are compared against
// hand-computed constants.
module tb_mfa_seq_ctrl;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int MERGE_CYCLES = 84;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic          start, abort;
  logic          bc_wen;
  logic [AW-1:0] bc_addr;
  logic [DW-1:0] bc_wdata;
  logic          sqg_wen;
  logic [AW-1:0] sqg_rd_addr, sqg_wr_addr;
  logic [DW-1:0] sqg_y;
  logic [AW-1:0] host_addr;
  logic          BC_mode, ram_wen, busy, done, err;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wdata;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];

  mfa_seq_ctrl #(
    .BOX_IDX(3), .DATA_LEN(8), .NPIX(64), .MERGE_CYCLES(MERGE_CYCLES)
  ) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .abort(abort),
    .bc_wen(bc_wen), .bc_addr(bc_addr), .bc_wdata(bc_wdata),
    .sqg_wen(sqg_wen), .sqg_rd_addr(sqg_rd_addr), .sqg_wr_addr(sqg_wr_addr),
    .sqg_y(sqg_y), .host_addr(host_addr),
    .BC_mode(BC_mode), .ram_wen(ram_wen), .ram_wr_addr(ram_wr_addr),
    .ram_wdata(ram_wdata), .ram_rd_addr(ram_rd_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge CLK) begin
    if (RST_n === 1'b1 && ram_wen !== 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ram_write unexpected wen=%b addr=%0d data=%0d",
                 ram_wen, ram_wr_addr, ram_wdata);
      end else begin
        check("ram_write", 32'({ram_wr_addr, ram_wdata}), 32'(exp_q.pop_front()));
      end
    end
  end

  // n pixel writes at addresses first..first+n-1 with data = address.
  task automatic bc_writes(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bc_wen   = 1'b1;
      bc_addr  = AW'(i);
      bc_wdata = DW'(i);
      exp_q.push_back({AW'(i), DW'(i)});
      @(negedge CLK);
      check("bc_rd_addr", 32'(ram_rd_addr), 32'(i));
      step();
      bc_wen = 1'b0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    RST_n = 1'b0; start = 0; abort = 0; bc_wen = 0; bc_addr = '0; bc_wdata = '0;
    sqg_wen = 0; sqg_rd_addr = '0; sqg_wr_addr = '0; sqg_y = '0; host_addr = '0;

    // Reset state.
    #12;
    check("rst_bc_mode", 32'(BC_mode), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    step();
    host_addr = 7'd17;
    #1 check("idle_host_rd", 32'(ram_rd_addr), 32'd17);

    // Frame 1: 64 writes, with one idle gap cycle, then MERGE.
    pulse_start();
    check("bc_busy", 32'(busy), 32'd1);
    check("bc_bc_mode", 32'(BC_mode), 32'd1);
    bc_writes(0, 10);
    step();                                   // gap: no strobe, no write
    bc_writes(10, 53);
    check("bc63_bc_mode", 32'(BC_mode), 32'd1);
    bc_writes(63, 1);
    check("merge_bc_mode", 32'(BC_mode), 32'd0);
    check("merge_busy", 32'(busy), 32'd1);

    // MERGE: sqg write on first cycle, stray pixel strobe at cycle 40.
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (BC_mode !== 1'b0) break;
      cnt++;
      if (c == 0) begin
        sqg_wen = 1'b1; sqg_wr_addr = 7'd72; sqg_y = 8'd9; sqg_rd_addr = 7'd5;
        exp_q.push_back({7'd72, 8'd9});
      end
      if (c == 40) begin
        bc_wen = 1'b1; bc_addr = 7'd3; bc_wdata = 8'hAA;
      end
      @(negedge CLK);
      if (c == 0) check("merge_rd_addr", 32'(ram_rd_addr), 32'd5);
      if (c == 40) check("merge_stray_wen", 32'(ram_wen), 32'd0);
      step();
      sqg_wen = 1'b0; bc_wen = 1'b0;
      if (c == 0) check("merge_err_clean", 32'(err), 32'd0);
      if (c == 40) check("merge_err_set", 32'(err), 32'd1);
    end
    check("merge_len", 32'(cnt), 32'(MERGE_CYCLES));
    check("done_done", 32'(done), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_bc_mode", 32'(BC_mode), 32'd1);

    // DONE: host sweep; pixel strobes must not reach the RAM.
    bc_wen = 1'b1;
    for (int a = 64; a < 128; a++) begin
      host_addr = AW'(a);
      #1 check("done_host_rd", 32'(ram_rd_addr), 32'(a));
      check("done_wen", 32'(ram_wen), 32'd0);
    end
    step();
    bc_wen = 1'b0;
    check("done_hold", 32'(done), 32'd1);

    // Frame 2 from DONE, aborted after 30 writes.
    pulse_start();
    check("f2_done", 32'(done), 32'd0);
    check("f2_busy", 32'(busy), 32'd1);
    bc_writes(0, 30);
    abort = 1'b1; bc_wen = 1'b1; bc_addr = 7'd31; bc_wdata = 8'd31;
    @(negedge CLK);
    check("abort_wen", 32'(ram_wen), 32'd0);
    step();
    abort = 1'b0; bc_wen = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bc_mode", 32'(BC_mode), 32'd1);
    check("abort_err_kept", 32'(err), 32'd1);

    // Frame 3: needs a full 64 writes again.
    pulse_start();
    bc_writes(0, 63);
    check("f3_63_bc_mode", 32'(BC_mode), 32'd1);
    check("f3_63_busy", 32'(busy), 32'd1);
    bc_writes(63, 1);
    check("f3_merge", 32'(BC_mode), 32'd0);
    step(); step(); step();

    // Asynchronous reset between edges, mid-MERGE.
    #2 RST_n = 1'b0;
    #1;
    check("arst_bc_mode", 32'(BC_mode), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;
    step();

    // sqg strobe while held: err, no write.
    sqg_wen = 1'b1; sqg_wr_addr = 7'd9; sqg_y = 8'd1;
    step();
    sqg_wen = 1'b0;
    check("sqg_held_err", 32'(err), 32'd1);

    // start while busy: err, frame continues.
    RST_n = 1'b0;
    #2;
    @(negedge CLK);
    RST_n = 1'b1;
    step();
    pulse_start();
    check("sb_err_clean", 32'(err), 32'd0);
    pulse_start();
    check("sb_err", 32'(err), 32'd1);
    check("sb_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
